// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   // Controller operating states
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_BUSY = 2'd1,
      HALTED  = 2'd2
   } state_t;

   // Bit positions inside the enable/flush/bubble control bundle
   localparam int CTL_PC_WRITE      = 0;
   localparam int CTL_IF_ID_WRITE   = 1;
   localparam int CTL_IF_ID_FLUSH   = 2;
   localparam int CTL_ID_EX_WRITE   = 3;
   localparam int CTL_ID_EX_BUBBLE  = 4;
   localparam int CTL_EX_MEM_WRITE  = 5;
   localparam int CTL_EX_MEM_BUBBLE = 6;
   localparam int CTL_MD_DONE       = 7;
   localparam int CTL_HALTED        = 8;
   localparam int CTL_W             = 9;

   // Free-running pipeline: every register loads, nothing is squashed
   localparam logic [CTL_W-1:0] CTL_RUN_DEFAULT =
      (CTL_W'(1) << CTL_PC_WRITE)    |
      (CTL_W'(1) << CTL_IF_ID_WRITE) |
      (CTL_W'(1) << CTL_ID_EX_WRITE) |
      (CTL_W'(1) << CTL_EX_MEM_WRITE);

   // MUL/DIV occupies EX: front end and ID/EX hold, EX/MEM receives bubbles
   localparam logic [CTL_W-1:0] CTL_MD_FREEZE =
      (CTL_W'(1) << CTL_EX_MEM_WRITE) |
      (CTL_W'(1) << CTL_EX_MEM_BUBBLE);

   // Legal MUL/DIV latency range and the counter width that covers it
   localparam int MD_LAT_MIN = 2;
   localparam int MD_LAT_MAX = 255;
   localparam int MD_CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // Count events, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: merges load-use,
// branch, data-memory wait, MUL/DIV occupancy and halt into register controls.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use,
   input  logic             branch_taken,
   input  logic             md_start,
   input  logic             dmem_stall,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             ex_mem_bubble,
   output logic             md_done,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   if (MD_LATENCY < MD_LAT_MIN || MD_LATENCY > MD_LAT_MAX) begin : g_bad_latency
      $error("pipeline_stall_ctrl: MD_LATENCY outside 2..255");
   end

   // Entry cycle plus the reload value plus the result cycle equals MD_LATENCY
   localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 2);

   state_t              state;
   state_t              state_nxt;
   logic [MD_CNT_W-1:0] md_cnt;
   logic [MD_CNT_W-1:0] md_cnt_nxt;
   logic [CTL_W-1:0]    ctl;
   logic                md_active;

   // MUL/DIV still has cycles to go before its result cycle
   assign md_active = (state == MD_BUSY) && (md_cnt != '0);

   // State and MUL/DIV countdown registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Next-state selection; a memory wait freezes everything outside HALTED
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      if (state == HALTED) begin
         if (resume) begin
            state_nxt = RUN;
         end
      end else if (!dmem_stall) begin
         if (md_active) begin
            md_cnt_nxt = md_cnt - MD_CNT_W'(1);
         end else if (halt_req) begin
            state_nxt = HALTED;
         end else if ((state == RUN) && md_start) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MD_RELOAD;
         end else begin
            state_nxt = RUN;
         end
      end
   end

   // Control bundle; the MUL/DIV result cycle behaves like RUN minus md_start
   always_comb begin
      ctl = CTL_RUN_DEFAULT;
      if (state == HALTED) begin
         ctl             = '0;
         ctl[CTL_HALTED] = 1'b1;
      end else if (dmem_stall) begin
         ctl = '0;
      end else if (md_active) begin
         ctl = CTL_MD_FREEZE;
      end else begin
         ctl[CTL_MD_DONE] = (state == MD_BUSY);
         if (halt_req) begin
            ctl[CTL_PC_WRITE]     = 1'b0;
            ctl[CTL_IF_ID_WRITE]  = 1'b0;
            ctl[CTL_ID_EX_BUBBLE] = 1'b1;
         end else if ((state == RUN) && md_start) begin
            ctl[CTL_PC_WRITE]      = 1'b0;
            ctl[CTL_IF_ID_WRITE]   = 1'b0;
            ctl[CTL_ID_EX_WRITE]   = 1'b0;
            ctl[CTL_EX_MEM_BUBBLE] = 1'b1;
         end else if (branch_taken) begin
            // Any load-use flag now belongs to a wrong-path instruction
            ctl[CTL_IF_ID_FLUSH]  = 1'b1;
            ctl[CTL_ID_EX_BUBBLE] = 1'b1;
         end else if (load_use) begin
            ctl[CTL_PC_WRITE]     = 1'b0;
            ctl[CTL_IF_ID_WRITE]  = 1'b0;
            ctl[CTL_ID_EX_BUBBLE] = 1'b1;
         end
      end
   end

   assign pc_write      = ctl[CTL_PC_WRITE];
   assign if_id_write   = ctl[CTL_IF_ID_WRITE];
   assign if_id_flush   = ctl[CTL_IF_ID_FLUSH];
   assign id_ex_write   = ctl[CTL_ID_EX_WRITE];
   assign id_ex_bubble  = ctl[CTL_ID_EX_BUBBLE];
   assign ex_mem_write  = ctl[CTL_EX_MEM_WRITE];
   assign ex_mem_bubble = ctl[CTL_EX_MEM_BUBBLE];
   assign md_done       = ctl[CTL_MD_DONE];
   assign halted        = ctl[CTL_HALTED];

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~ctl[CTL_PC_WRITE]),
      .clr   (cnt_clr),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctl[CTL_IF_ID_FLUSH]),
      .clr   (cnt_clr),
      .cnt   (flush_cnt)
   );

`ifndef SYNTHESIS
   // Only one instruction can be in EX, so MUL/DIV and a taken branch cannot coexist
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(md_start && branch_taken))
            else $error("pipeline_stall_ctrl: md_start and branch_taken together");
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed cycle table, reset/saturation
// sequences, and randomized traffic against a behavioural model.
module tb_pipeline_stall_ctrl;

   localparam int MD_LAT = 4;
   localparam int CW     = 4;
   localparam int CMAX   = (1 << CW) - 1;

   // Output vector order: {pc, if_id_w, if_id_flush, id_ex_w, id_ex_bub, ex_mem_w, ex_mem_bub, md_done, halted}
   localparam logic [8:0] DEF  = 9'b1_1_0_1_0_1_0_0_0;
   localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_0_0_0;
   localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_0_0_0;
   localparam logic [8:0] MDF  = 9'b0_0_0_0_0_1_1_0_0;
   localparam logic [8:0] DONE = 9'b1_1_0_1_0_1_0_1_0;
   localparam logic [8:0] DBR  = 9'b1_1_1_1_1_1_0_1_0;
   localparam logic [8:0] STL  = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] HLT  = 9'b0_0_0_0_0_0_0_0_1;

   // Input vector order: {load_use, branch_taken, md_start, dmem_stall, halt_req, resume, cnt_clr}
   localparam logic [6:0] I_NONE = 7'b0000000;
   localparam logic [6:0] I_LU   = 7'b1000000;
   localparam logic [6:0] I_BR   = 7'b0100000;
   localparam logic [6:0] I_MD   = 7'b0010000;
   localparam logic [6:0] I_DM   = 7'b0001000;
   localparam logic [6:0] I_HR   = 7'b0000100;
   localparam logic [6:0] I_RS   = 7'b0000010;
   localparam logic [6:0] I_CLR  = 7'b0000001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_use = 1'b0, branch_taken = 1'b0, md_start = 1'b0, dmem_stall = 1'b0;
   logic halt_req = 1'b0, resume = 1'b0, cnt_clr = 1'b0;
   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
   logic ex_mem_write, ex_mem_bubble, md_done, halted;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [8:0] outs;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [6:0] iv;
      logic [8:0] o;
      int         s;
      int         f;
   } vec_t;
   vec_t tbl[$];

   // Behavioural model state
   bit m_halted;
   int m_md_left;
   int m_stall;
   int m_flush;

   always #5 clk = ~clk;

   assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                  ex_mem_write, ex_mem_bubble, md_done, halted};

   pipeline_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_use      (load_use),
      .branch_taken  (branch_taken),
      .md_start      (md_start),
      .dmem_stall    (dmem_stall),
      .halt_req      (halt_req),
      .resume        (resume),
      .cnt_clr       (cnt_clr),
      .pc_write      (pc_write),
      .if_id_write   (if_id_write),
      .if_id_flush   (if_id_flush),
      .id_ex_write   (id_ex_write),
      .id_ex_bubble  (id_ex_bubble),
      .ex_mem_write  (ex_mem_write),
      .ex_mem_bubble (ex_mem_bubble),
      .md_done       (md_done),
      .halted        (halted),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [6:0] iv);
      {load_use, branch_taken, md_start, dmem_stall, halt_req, resume, cnt_clr} = iv;
   endtask

   // One clock cycle: outputs checked mid-cycle, counters just after the edge
   task automatic do_cycle(input string name, input logic [6:0] iv, input logic [8:0] eo,
                           input int es, input int ef);
      drive(iv);
      @(negedge clk);
      check({name, "_outs"}, 32'(outs), 32'(eo));
      @(posedge clk);
      #1;
      check({name, "_stall"}, 32'(stall_cnt), 32'(es));
      check({name, "_flush"}, 32'(flush_cnt), 32'(ef));
   endtask

   task automatic add(input logic [6:0] iv, input logic [8:0] o, input int s, input int f);
      vec_t v;
      v.iv = iv; v.o = o; v.s = s; v.f = f;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      drive(I_NONE);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", 32'(outs), 32'(DEF));
      check("reset_stall", 32'(stall_cnt), 32'd0);
      check("reset_flush", 32'(flush_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_halted = 1'b0; m_md_left = 0; m_stall = 0; m_flush = 0;
   endtask

   // Model: MUL/DIV tracked as cycles of EX occupancy still to come
   task automatic model_eval(input logic [6:0] iv, output logic [8:0] o, output bit fev,
                             output bit nh, output int nmd);
      logic lu, br, ms, dm, hr, rs, cc;
      logic pc, ifw, fl, idw, bub, emw, emb, dn, h;
      {lu, br, ms, dm, hr, rs, cc} = iv;
      pc = 1; ifw = 1; fl = 0; idw = 1; bub = 0; emw = 1; emb = 0; dn = 0; h = 0;
      fev = 0; nh = m_halted; nmd = m_md_left;
      if (m_halted) begin
         pc = 0; ifw = 0; idw = 0; emw = 0; h = 1;
         if (rs) nh = 0;
      end else if (dm) begin
         pc = 0; ifw = 0; idw = 0; emw = 0;
      end else if (m_md_left > 1) begin
         pc = 0; ifw = 0; idw = 0; emb = 1;
         nmd = m_md_left - 1;
      end else begin
         if (m_md_left == 1) begin
            dn = 1; nmd = 0;
         end
         if (hr) begin
            pc = 0; ifw = 0; bub = 1; nh = 1;
         end else if (ms && m_md_left == 0) begin
            pc = 0; ifw = 0; idw = 0; emb = 1; nmd = MD_LAT - 1;
         end else if (br) begin
            fl = 1; bub = 1; fev = 1;
         end else if (lu) begin
            pc = 0; ifw = 0; bub = 1;
         end
      end
      o = {pc, ifw, fl, idw, bub, emw, emb, dn, h};
   endtask

   initial begin
      logic [8:0] eo;
      logic [6:0] iv;
      bit fev, nh;
      int nmd;

      // Directed cycle table, starting from reset
      add(I_LU,        LU,   1, 0);
      add(I_NONE,      DEF,  1, 0);
      add(I_CLR,       DEF,  0, 0);
      add(I_BR | I_LU, BR,   0, 1);
      add(I_NONE,      DEF,  0, 1);
      add(I_CLR,       DEF,  0, 0);
      add(I_MD,        MDF,  1, 0);
      add(I_NONE,      MDF,  2, 0);
      add(I_NONE,      MDF,  3, 0);
      add(I_NONE,      DONE, 3, 0);
      add(I_NONE,      DEF,  3, 0);
      add(I_CLR,       DEF,  0, 0);
      add(I_MD,        MDF,  1, 0);
      add(I_DM,        STL,  2, 0);
      add(I_DM,        STL,  3, 0);
      add(I_NONE,      MDF,  4, 0);
      add(I_NONE,      MDF,  5, 0);
      add(I_NONE,      DONE, 5, 0);
      add(I_CLR,       DEF,  0, 0);
      add(I_HR,        LU,   1, 0);
      add(I_DM,        HLT,  2, 0);
      add(I_NONE,      HLT,  3, 0);
      add(I_BR,        HLT,  4, 0);
      add(I_RS,        HLT,  5, 0);
      add(I_NONE,      DEF,  5, 0);
      add(I_RS,        DEF,  5, 0);
      add(I_CLR,       DEF,  0, 0);
      add(I_MD,        MDF,  1, 0);
      add(I_BR,        MDF,  2, 0);
      add(I_HR,        MDF,  3, 0);
      add(I_BR,        DBR,  3, 1);
      add(I_NONE,      DEF,  3, 1);
      add(I_DM | I_CLR, STL, 0, 0);

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         do_cycle($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].o, tbl[i].s, tbl[i].f);
      end

      // Reset in the middle of MD_BUSY: straight back to RUN, no md_done
      do_cycle("rstmd_entry", I_MD, MDF, 1, 0);
      drive(I_NONE);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmd_outs", 32'(outs), 32'(DEF));
      check("rstmd_stall", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) do_cycle($sformatf("rstmd_after%0d", i), I_NONE, DEF, 0, 0);

      // Reset while HALTED
      do_cycle("rsth_req", I_HR, LU, 1, 0);
      do_cycle("rsth_hold", I_NONE, HLT, 2, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rsth_outs", 32'(outs), 32'(DEF));
      check("rsth_stall", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_cycle("rsth_after", I_NONE, DEF, 0, 0);

      // Stall counter saturation, then clear beats increment
      for (int i = 1; i <= 20; i++)
         do_cycle($sformatf("sat%0d", i), I_LU, LU, (i > CMAX) ? CMAX : i, 0);
      do_cycle("sat_clr", I_LU | I_CLR, LU, 0, 0);
      do_cycle("sat_after", I_LU, LU, 1, 0);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic lu, br, ms, dm, hr, rs, cc;
         lu = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 6) == 0);
         ms = !br && ($urandom_range(0, 9) == 0);
         dm = ($urandom_range(0, 6) == 0);
         hr = ($urandom_range(0, 29) == 0);
         rs = ($urandom_range(0, 4) == 0);
         cc = ($urandom_range(0, 59) == 0);
         iv = {lu, br, ms, dm, hr, rs, cc};
         model_eval(iv, eo, fev, nh, nmd);
         drive(iv);
         @(negedge clk);
         check($sformatf("rnd%0d_outs", i), 32'(outs), 32'(eo));
         @(posedge clk);
         #1;
         m_halted = nh;
         m_md_left = nmd;
         if (cc) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (!eo[8] && m_stall < CMAX) m_stall++;
            if (fev && m_flush < CMAX) m_flush++;
         end
         check($sformatf("rnd%0d_stall", i), 32'(stall_cnt), 32'(m_stall));
         check($sformatf("rnd%0d_flush", i), 32'(flush_cnt), 32'(m_flush));
      end

      drive(I_NONE);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
